// File: rtl/mem_bus_if_pkg.sv
// Shared constants and state encoding for the data-side Wishbone bus master.
package mem_bus_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } bus_state_e;

    localparam logic        RstEnable = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [5:0]  NoStall   = 6'b00_0000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// MEM-stage Wishbone classic master: one access per request, stalls the
// pipeline until ack/timeout/flush, and holds load data across pipeline stalls.
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [7:0] ToLast    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic       ToEnabled = (TIMEOUT_CYCLES != 0);

    bus_state_e  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        timeout_hit;

    // The counter starts at 0 in the first BUSY cycle, so the last allowed
    // busy cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign timeout_hit = ToEnabled && (cnt_q == ToLast);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q  <= IDLE;
            adr_q    <= ZeroWord;
            dat_q    <= ZeroWord;
            sel_q    <= 4'h0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= ZeroWord;
            cnt_q    <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stallreq   = NoStop;
        cpu_data_o = ZeroWord;

        unique case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush) begin
                    stallreq = Stop;
                    adr_d    = cpu_addr_i;
                    dat_d    = cpu_data_i;
                    sel_d    = cpu_sel_i;
                    we_d     = cpu_we_i;
                    cyc_d    = 1'b1;
                    cnt_d    = 8'h00;
                    state_d  = BUSY;
                end else begin
                    adr_d = ZeroWord;
                    dat_d = ZeroWord;
                    sel_d = 4'h0;
                    we_d  = 1'b0;
                    cyc_d = 1'b0;
                end
            end

            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    rd_buf_d = we_q ? ZeroWord : wb_dat_i;
                    if (!we_q) begin
                        cpu_data_o = wb_dat_i;
                    end
                    state_d = (stall == NoStall) ? IDLE : HOLD;
                end else if (timeout_hit) begin
                    rd_buf_d = ZeroWord;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stallreq = Stop;
                    cnt_d    = sat_inc8(cnt_q);
                end
                // Bus fields are cleared as soon as the cycle ends so HOLD and
                // IDLE both present an idle bus.
                if (state_d != BUSY) begin
                    adr_d = ZeroWord;
                    dat_d = ZeroWord;
                    sel_d = 4'h0;
                    we_d  = 1'b0;
                    cyc_d = 1'b0;
                end
            end

            HOLD: begin
                cpu_data_o = rd_buf_q;
                if (flush || (stall == NoStall)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign bus_err_o = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: per-cycle vector table plus hand-written
// flush, timeout, and asynchronous reset sequences.
module tb_mem_bus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int unsigned total;
    int unsigned bad;

    mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .bus_err_o  (bus_err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        ack;
        logic [31:0] rdat;
        logic [5:0]  stl;
        logic        fl;
        logic        x_sreq;
        logic        x_cyc;
        logic        x_we;
        logic [31:0] x_adr;
        logic [3:0]  x_sel;
        logic [31:0] x_dat;
        logic [31:0] x_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ce, input logic we, input logic [31:0] adr, input logic [3:0] sel,
        input logic [31:0] wdat, input logic ack, input logic [31:0] rdat,
        input logic [5:0] stl, input logic fl,
        input logic x_sreq, input logic x_cyc, input logic x_we, input logic [31:0] x_adr,
        input logic [3:0] x_sel, input logic [31:0] x_dat, input logic [31:0] x_data);
        vec_t v;
        v.ce = ce; v.we = we; v.adr = adr; v.sel = sel; v.wdat = wdat;
        v.ack = ack; v.rdat = rdat; v.stl = stl; v.fl = fl;
        v.x_sreq = x_sreq; v.x_cyc = x_cyc; v.x_we = x_we; v.x_adr = x_adr;
        v.x_sel = x_sel; v.x_dat = x_dat; v.x_data = x_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 6'b0; flush = 1'b0;
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_sel_i = 4'h0; cpu_data_i = 32'h0;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, ".cyc"}, {31'b0, wb_cyc_o}, 32'h0);
        chk({tag, ".stb"}, {31'b0, wb_stb_o}, 32'h0);
        chk({tag, ".adr"}, wb_adr_o, 32'h0);
        chk({tag, ".dat"}, wb_dat_o, 32'h0);
        chk({tag, ".sel"}, {28'b0, wb_sel_o}, 32'h0);
        chk({tag, ".we"},  {31'b0, wb_we_o}, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b0;

        // Per-cycle vectors: inputs for the cycle, outputs seen mid-cycle.
        // zero-wait load
        tbl.push_back(mk(1,0,32'h100,4'hF,0, 0,0,          6'b0,0, 1,0,0,32'h0,  4'h0,0,           0));
        tbl.push_back(mk(0,0,0,0,0,          1,32'hDEADBEEF,6'b0,0, 0,1,0,32'h100,4'hF,0,           32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b0,0, 0,0,0,32'h0,  4'h0,0,           0));
        // store, 3 wait states, cpu_* wiggles ignored while busy
        tbl.push_back(mk(1,1,32'h200,4'h3,32'h12345678, 0,0, 6'b0,0, 1,0,0,32'h0,4'h0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,0,32'hFFF0,4'hF,0, 0,0, 6'b0,0, 1,1,1,32'h200,4'h3,32'h12345678,0));
        tbl.push_back(mk(0,0,0,0,0,          1,32'hAAAA5555,6'b0,0, 0,1,1,32'h200,4'h3,32'h12345678,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b0,0, 0,0,0,32'h0,  4'h0,0,           0));
        // load acked under stall -> HOLD keeps the data
        tbl.push_back(mk(1,0,32'h300,4'hF,0, 0,0,          6'b0,0,      1,0,0,32'h0,  4'h0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          1,32'hCAFEF00D,6'b001111,0, 0,1,0,32'h300,4'hF,0,32'hCAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b001111,0, 0,0,0,32'h0,  4'h0,0,32'hCAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,          1,32'h11111111,6'b001111,0, 0,0,0,32'h0, 4'h0,0,32'hCAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b001111,0, 0,0,0,32'h0,  4'h0,0,32'hCAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b0,0,      0,0,0,32'h0,  4'h0,0,32'hCAFEF00D));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b0,0,      0,0,0,32'h0,  4'h0,0,0));
        // back-to-back loads
        tbl.push_back(mk(1,0,32'h400,4'hF,0, 0,0,          6'b0,0, 1,0,0,32'h0,  4'h0,0,0));
        tbl.push_back(mk(1,0,32'h500,4'hC,0, 1,32'h01020304,6'b0,0, 0,1,0,32'h400,4'hF,0,32'h01020304));
        tbl.push_back(mk(1,0,32'h500,4'hC,0, 0,0,          6'b0,0, 1,0,0,32'h0,  4'h0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          1,32'h05060708,6'b0,0, 0,1,0,32'h500,4'hC,0,32'h05060708));
        // stray ack in IDLE, request under flush
        tbl.push_back(mk(0,0,0,0,0,          1,32'h99999999,6'b0,0, 0,0,0,32'h0,  4'h0,0,0));
        tbl.push_back(mk(1,0,32'h900,4'hF,0, 0,0,          6'b0,1, 0,0,0,32'h0,  4'h0,0,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,          6'b0,0, 0,0,0,32'h0,  4'h0,0,0));

        // reset state
        #12;
        chk_bus_idle("reset");
        chk("reset.sreq", {31'b0, stallreq}, 32'h0);
        chk("reset.err",  {31'b0, bus_err_o}, 32'h0);
        chk("reset.data", cpu_data_o, 32'h0);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            cpu_ce_i = tbl[i].ce; cpu_we_i = tbl[i].we; cpu_addr_i = tbl[i].adr;
            cpu_sel_i = tbl[i].sel; cpu_data_i = tbl[i].wdat;
            wb_ack_i = tbl[i].ack; wb_dat_i = tbl[i].rdat;
            stall = tbl[i].stl; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("r%0d.sreq", i), {31'b0, stallreq}, {31'b0, tbl[i].x_sreq});
            chk($sformatf("r%0d.cyc", i),  {31'b0, wb_cyc_o}, {31'b0, tbl[i].x_cyc});
            chk($sformatf("r%0d.stb", i),  {31'b0, wb_stb_o}, {31'b0, tbl[i].x_cyc});
            chk($sformatf("r%0d.we", i),   {31'b0, wb_we_o},  {31'b0, tbl[i].x_we});
            chk($sformatf("r%0d.adr", i),  wb_adr_o, tbl[i].x_adr);
            chk($sformatf("r%0d.sel", i),  {28'b0, wb_sel_o}, {28'b0, tbl[i].x_sel});
            chk($sformatf("r%0d.dat", i),  wb_dat_o, tbl[i].x_dat);
            chk($sformatf("r%0d.data", i), cpu_data_o, tbl[i].x_data);
            chk($sformatf("r%0d.err", i),  {31'b0, bus_err_o}, 32'h0);
            tick();
        end
        idle_inputs();

        // flush together with ack: flush wins
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("fl.busy.cyc", {31'b0, wb_cyc_o}, 32'h1);
        chk("fl.busy.sreq", {31'b0, stallreq}, 32'h1);
        tick();
        flush = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hBADC0DE0;
        @(negedge clk);
        chk("fl.ack.sreq", {31'b0, stallreq}, 32'h0);
        chk("fl.ack.data", cpu_data_o, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk_bus_idle("fl.after");
        chk("fl.after.sreq", {31'b0, stallreq}, 32'h0);
        chk("fl.after.data", cpu_data_o, 32'h0);
        tick();

        // timeout after 4 busy cycles
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h700; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to.b%0d.cyc", k), {31'b0, wb_cyc_o}, 32'h1);
            chk($sformatf("to.b%0d.sreq", k), {31'b0, stallreq}, (k < 3) ? 32'h1 : 32'h0);
            chk($sformatf("to.b%0d.err", k), {31'b0, bus_err_o}, 32'h0);
            tick();
        end
        @(negedge clk);
        chk("to.err", {31'b0, bus_err_o}, 32'h1);
        chk("to.cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("to.sreq", {31'b0, stallreq}, 32'h0);
        chk("to.data", cpu_data_o, 32'h0);
        tick();
        @(negedge clk);
        chk("to.err.drop", {31'b0, bus_err_o}, 32'h0);
        tick();

        // flush beats a timeout maturing in the same cycle
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h710; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flto.cyc", {31'b0, wb_cyc_o}, 32'h1);
        chk("flto.sreq", {31'b0, stallreq}, 32'h0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flto.err", {31'b0, bus_err_o}, 32'h0);
        chk("flto.cyc.drop", {31'b0, wb_cyc_o}, 32'h0);
        tick();

        // asynchronous reset mid-access
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h800; cpu_sel_i = 4'hF; cpu_we_i = 1'b1; cpu_data_i = 32'h55AA55AA;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("ar.busy.cyc", {31'b0, wb_cyc_o}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk_bus_idle("ar.async");
        chk("ar.async.sreq", {31'b0, stallreq}, 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h804; cpu_sel_i = 4'hF;
        @(negedge clk);
        chk("ar.req.sreq", {31'b0, stallreq}, 32'h1);
        chk("ar.req.cyc", {31'b0, wb_cyc_o}, 32'h0);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h76543210;
        @(negedge clk);
        chk("ar.ack.cyc", {31'b0, wb_cyc_o}, 32'h1);
        chk("ar.ack.adr", wb_adr_o, 32'h804);
        chk("ar.ack.data", cpu_data_o, 32'h76543210);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("ar.done.cyc", {31'b0, wb_cyc_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
